disp_data_formatter: RTL and testbench

//  Upstream feeder of the 4-digit 7-segment display driver. Converts a binary count (0-99)
//  to two BCD digits with an iterative shift-add-3 FSM and encodes units, tens, state number
//  and activity flag into active-low cathode patterns. Also generates the clk_disp refresh

---
 rtl/disp_data_formatter.sv | 153 +++++++++++++++
 tb/tb_disp_data_formatter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_data_formatter.sv
// disp_data_formatter: binary count to BCD and 7-segment patterns,
// plus the refresh clock that steps the display driver's digit scan.
//
// Ports:
//   clk          system clock, all registers on its rising edge
//   rst          synchronous active-low reset
//   load         1-cycle strobe capturing valor/estado_num/actividad_in
//   valor        binary count 0-99 (larger values clamp to 99)
//   estado_num   state number, shown as hex digit
//   actividad_in 1 shows 'A', 0 shows 'U'
//   Unidades     cathode pattern, units digit
//   Decenas      cathode pattern, tens digit
//   Estado       cathode pattern, state digit
//   Actividad    cathode pattern, activity letter
//   busy         high while a conversion is in flight
//   clk_disp     refresh clock, clk/(2*DIV)
module disp_data_formatter #(
  parameter int DIV      = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] valor,
  input  logic [3:0] estado_num,
  input  logic       actividad_in,
  output logic [6:0] Unidades,
  output logic [6:0] Decenas,
  output logic [6:0] Estado,
  output logic [6:0] Actividad,
  output logic       busy,
  output logic       clk_disp
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DIV - 1);

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] SEG_U = 7'b1000001;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    UPD
  } state_t;

  state_t      state;
  logic [6:0]  bin;
  logic [7:0]  bcd;
  logic [2:0]  cnt;
  logic [3:0]  est;
  logic        act;
  logic [DW-1:0] div_cnt;

  logic [6:0]  vclamp;
  logic [7:0]  bcd_adj;
  logic [14:0] sh;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0010000;
      4'hA: p = 7'b0001000;
      4'hB: p = 7'b0000011;
      4'hC: p = 7'b1000110;
      4'hD: p = 7'b0100001;
      4'hE: p = 7'b0000110;
      default: p = 7'b0001110;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    vclamp  = (valor > 7'd99) ? 7'd99 : valor;
    bcd_adj = {add3(bcd[7:4]), add3(bcd[3:0])};
    // top bit of the 15-bit shift falls off; tens never exceeds 9
    sh      = {bcd_adj, bin} << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      est       <= '0;
      act       <= 1'b0;
      busy      <= 1'b0;
      Unidades  <= BLANK;
      Decenas   <= BLANK;
      Estado    <= BLANK;
      Actividad <= BLANK;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            bin   <= vclamp;
            bcd   <= '0;
            cnt   <= '0;
            est   <= estado_num;
            act   <= actividad_in;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          bcd <= sh[14:7];
          bin <= sh[6:0];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd6)
            state <= UPD;
        end
        UPD: begin
          Unidades  <= seg(bcd[3:0]);
          Decenas   <= (BLANK_LZ && bcd[7:4] == 4'd0)
                       ? BLANK : seg(bcd[7:4]);
          Estado    <= seg(est);
          Actividad <= act ? seg(4'hA) : SEG_U;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // free-running refresh divider, independent of the converter
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt  <= '0;
      clk_disp <= 1'b0;
    end else if (div_cnt == DMAX) begin
      div_cnt  <= '0;
      clk_disp <= ~clk_disp;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_disp_data_formatter.sv
// tb_disp_data_formatter: scoreboard bench for disp_data_formatter.
// Two instances share stimulus: BLANK_LZ=1 and BLANK_LZ=0, both DIV=4.
module tb_disp_data_formatter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [6:0] valor = '0;
  logic [3:0] estado_num = '0;
  logic       actividad_in = 1'b0;

  logic [6:0] uni, dec, est, act;
  logic       busy, clk_disp;
  logic [6:0] uni0, dec0, est0, act0;
  logic       busy0, clk_disp0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         n;
    logic [6:0] dec;
    logic [6:0] uni;
    logic [6:0] est;
    logic [6:0] act;
    logic [6:0] dec0;
  } exp_t;

  exp_t q[$];

  disp_data_formatter #(.DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .valor(valor),
    .estado_num(estado_num), .actividad_in(actividad_in),
    .Unidades(uni), .Decenas(dec), .Estado(est),
    .Actividad(act), .busy(busy), .clk_disp(clk_disp)
  );

  disp_data_formatter #(.DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .valor(valor),
    .estado_num(estado_num), .actividad_in(actividad_in),
    .Unidades(uni0), .Decenas(dec0), .Estado(est0),
    .Actividad(act0), .busy(busy0), .clk_disp(clk_disp0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: output event is busy falling while out of reset
  bit bprev = 1'b0;
  bit cdprev = 1'b0;
  int last_rise = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        bprev = 1'b0;
        last_rise = -1;
      end else begin
        if (bprev && !busy) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("latency", cyc - e.n, 8);
            chk("Decenas", int'(dec), int'(e.dec));
            chk("Unidades", int'(uni), int'(e.uni));
            chk("Estado", int'(est), int'(e.est));
            chk("Actividad", int'(act), int'(e.act));
            chk("Decenas_nolz", int'(dec0), int'(e.dec0));
          end
        end
        bprev = busy;
        if (clk_disp && !cdprev) begin
          if (last_rise >= 0)
            chk("clk_disp_period", cyc - last_rise, 8);
          last_rise = cyc;
        end
      end
      cdprev = clk_disp;
    end
  end

  // one conversion; reld>0 re-pulses load with 88 at edge N+reld
  task automatic run(
    input logic [6:0] v, input logic [3:0] s, input logic a,
    input logic [6:0] e_dec, input logic [6:0] e_uni,
    input logic [6:0] e_est, input logic [6:0] e_act,
    input logic [6:0] e_dec0, input int reld
  );
    exp_t e;
    valor = v;
    estado_num = s;
    actividad_in = a;
    load = 1'b1;
    e.n = cyc + 1;
    e.dec = e_dec;
    e.uni = e_uni;
    e.est = e_est;
    e.act = e_act;
    e.dec0 = e_dec0;
    q.push_back(e);
    step();
    load = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == reld) begin
        valor = 7'd88;
        estado_num = 4'h5;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
      chk("busy", int'(busy), (i < 8) ? 1 : 0);
    end
    load = 1'b0;
  endtask

  initial begin
    // reset held two cycles
    step();
    step();
    chk("rst_dec", int'(dec), 'h7F);
    chk("rst_uni", int'(uni), 'h7F);
    chk("rst_est", int'(est), 'h7F);
    chk("rst_act", int'(act), 'h7F);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clk_disp", int'(clk_disp), 0);
    rst = 1'b1;

    // divider: first rise at edge 4, fall at edge 8
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("clk_disp_seq", int'(clk_disp), (k / 4) % 2);
    end
    chk("idle_dec", int'(dec), 'h7F);

    run(7'd47, 4'h3, 1'b1, 7'b0011001, 7'b1111000,
        7'b0110000, 7'b0001000, 7'b0011001, 0);
    run(7'd5, 4'h0, 1'b0, 7'b1111111, 7'b0010010,
        7'b1000000, 7'b1000001, 7'b1000000, 0);
    run(7'd127, 4'hE, 1'b1, 7'b0010000, 7'b0010000,
        7'b0000110, 7'b0001000, 7'b0010000, 0);
    run(7'd100, 4'hF, 1'b0, 7'b0010000, 7'b0010000,
        7'b0001110, 7'b1000001, 7'b0010000, 0);
    run(7'd0, 4'h0, 1'b1, 7'b1111111, 7'b1000000,
        7'b1000000, 7'b0001000, 7'b1000000, 0);
    run(7'd90, 4'hB, 1'b1, 7'b0010000, 7'b1000000,
        7'b0000011, 7'b0001000, 7'b0010000, 0);
    // second load at N+3 while busy is ignored
    run(7'd12, 4'h9, 1'b0, 7'b1111001, 7'b0100100,
        7'b0010000, 7'b1000001, 7'b1111001, 3);
    step();
    chk("ignored_load_busy", int'(busy), 0);
    chk("ignored_load_uni", int'(uni), 'b0100100);

    // reset at N+4 aborts with no partial update
    valor = 7'd12;
    estado_num = 4'h1;
    actividad_in = 1'b1;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    chk("abort_busy_pre", int'(busy), 1);
    rst = 1'b0;
    step();
    chk("abort_dec", int'(dec), 'h7F);
    chk("abort_uni", int'(uni), 'h7F);
    chk("abort_est", int'(est), 'h7F);
    chk("abort_act", int'(act), 'h7F);
    chk("abort_busy", int'(busy), 0);
    chk("abort_clk_disp", int'(clk_disp), 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("abort_hold_uni", int'(uni), 'h7F);
    chk("abort_hold_busy", int'(busy), 0);

    run(7'd63, 4'h7, 1'b0, 7'b0000010, 7'b0110000,
        7'b1111000, 7'b1000001, 7'b0000010, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
